branch_sched: RTL

- Sequences the branch comparator (in1/in2/type -> zero) for the pipelined MIPS core.
- Accepts a decoded branch from the D stage and stalls D until the forwarded operands are ready.
- Drives the comparator from registered operands and issues a one-cycle PC redirect when the branch is taken.
- Handles exception/interrupt flush and keeps saturating outcome counters for CP0 debug reads.

---
 rtl/branch_sched_pkg.sv | 18 +
 rtl/branch_sched_sat_counter.sv | 25 ++
 rtl/branch_sched.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/branch_sched_pkg.sv
// Shared constants for the branch scheduler: branch type codes, FSM states
// and the default outcome-counter width.
`default_nettype none
package branch_sched_pkg;

  localparam logic [5:0] BEQ_T     = 6'b001000;
  localparam logic [5:0] BNE_T     = 6'b001001;
  localparam int         CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_RESOLVE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/branch_sched_sat_counter.sv
// Saturating up-counter: stops at all-ones, cleared only by reset.
`default_nettype none
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/branch_sched.sv
// Branch scheduler: waits for forwarded operands, drives the external
// comparator from registers, and issues a one-cycle redirect when taken.
`default_nettype none
module branch_sched
  import branch_sched_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int MAX_WAIT = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             br_valid,
  input  logic [5:0]       br_type,
  input  logic [31:0]      br_target,
  input  logic             rs_ready,
  input  logic             rt_ready,
  input  logic [31:0]      rs_val,
  input  logic [31:0]      rt_val,
  input  logic             flush,
  input  logic             cmp_result,
  output logic [31:0]      cmp_in1,
  output logic [31:0]      cmp_in2,
  output logic [5:0]       cmp_type,
  output logic             stall_d,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             br_done,
  output logic             wait_err,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] total_cnt
);

  localparam int WCNT_W = $clog2(MAX_WAIT + 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [31:0]         r_cmp_in1;
  logic [31:0]         r_cmp_in2;
  logic [5:0]          r_cmp_type;
  logic [31:0]         r_target;
  logic                r_taken;
  logic [WCNT_W-1:0]   r_wait_cnt;
  logic                r_wait_err;

  logic w_ops_ready;
  logic w_latch;
  logic w_clr_wait;
  logic w_inc_wait;
  logic w_sample;
  logic w_done;

  assign w_ops_ready = rs_ready && rt_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_clr_wait  = 1'b0;
    w_inc_wait  = 1'b0;
    w_sample    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (br_valid) begin
          if (w_ops_ready) begin
            w_latch     = 1'b1;
            w_state_nxt = S_RESOLVE;
          end else begin
            w_clr_wait  = 1'b1;
            w_state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (w_ops_ready) begin
          w_latch     = 1'b1;
          w_state_nxt = S_RESOLVE;
        end else begin
          w_inc_wait  = 1'b1;
        end
      end
      S_RESOLVE: begin
        w_sample    = 1'b1;
        w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    // A flush kills whatever this cycle would have committed, including an accept.
    if (flush) begin
      w_state_nxt = S_IDLE;
      w_latch     = 1'b0;
      w_clr_wait  = 1'b0;
      w_inc_wait  = 1'b0;
      w_sample    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_cmp_in1  <= '0;
      r_cmp_in2  <= '0;
      r_cmp_type <= '0;
      r_target   <= '0;
      r_taken    <= 1'b0;
      r_wait_cnt <= '0;
      r_wait_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_latch) begin
        r_cmp_in1  <= rs_val;
        r_cmp_in2  <= rt_val;
        r_cmp_type <= br_type;
        r_target   <= br_target;
      end
      if (w_sample) begin
        r_taken <= cmp_result;
      end
      if (w_clr_wait) begin
        r_wait_cnt <= '0;
      end else if (w_inc_wait && (r_wait_cnt != WCNT_W'(MAX_WAIT))) begin
        r_wait_cnt <= r_wait_cnt + WCNT_W'(1);
        if (r_wait_cnt == WCNT_W'(MAX_WAIT - 1)) begin
          r_wait_err <= 1'b1;
        end
      end
    end
  end

  assign w_done = (r_state == S_DONE) && !flush;

  // Reset gating keeps stall_d low while reset is held even if D presents a branch.
  assign stall_d = reset && !flush &&
                   ((r_state == S_WAIT) || (r_state == S_RESOLVE) ||
                    ((r_state == S_IDLE) && br_valid));

  assign br_done        = w_done;
  assign redirect_valid = w_done && r_taken;
  assign redirect_pc    = redirect_valid ? r_target : 32'h0;
  assign cmp_in1        = r_cmp_in1;
  assign cmp_in2        = r_cmp_in2;
  assign cmp_type       = r_cmp_type;
  assign wait_err       = r_wait_err;

  sat_counter #(.W(CNT_W)) u_total_cnt (
    .clk     (clk),
    .rst_n   (reset),
    .i_inc   (w_done),
    .o_count (total_cnt)
  );

  sat_counter #(.W(CNT_W)) u_taken_cnt (
    .clk     (clk),
    .rst_n   (reset),
    .i_inc   (w_done && r_taken),
    .o_count (taken_cnt)
  );

endmodule
`default_nettype wire
